// File: rtl/fp_f32_to_sfp.sv
// fp_f32_to_sfp: binary32 -> signed fixed-point converter (IW int bits, QW frac bits).
// Rounds half away from zero, saturates to the WL-bit range, flags NaN and clipping.
// Ports: clk, rst_n (sync, active low)
//        in_valid/in_ready/in_f32           : float input handshake
//        out_valid/out_ready                : result handshake
//        out_val (WL bits), out_sat, out_nan : registered result and flags
module fp_f32_to_sfp #(
    parameter int IW = 4,
    parameter int QW = 12,
    localparam int WL = IW + QW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_f32,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [WL-1:0] out_val,
    output logic          out_sat,
    output logic          out_nan
);

    localparam logic signed [9:0] QW_S    = 10'(QW);
    localparam logic [WL:0]       HALF    = (WL+1)'(64'd1 << (WL-1));
    localparam logic [WL:0]       HALF_M1 = HALF - (WL+1)'(1);
    localparam logic [WL-1:0]     MAXP    = HALF_M1[WL-1:0];
    localparam logic [WL-1:0]     MINN    = HALF[WL-1:0];

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // S1: unpack and classify
    logic [7:0]        exp_f;
    logic              sp_c;
    logic signed [9:0] k_c;

    assign exp_f = in_f32[30:23];
    assign sp_c  = (exp_f == 8'hFF);
    assign k_c   = $signed({2'b00, exp_f}) - 10'sd150 + QW_S;

    logic              v1, sign1, nan1, inf1, norm1;
    logic [22:0]       man1;
    logic signed [9:0] k1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
        end else if (advance) begin
            v1    <= in_valid;
            sign1 <= in_f32[31];
            nan1  <= sp_c && (in_f32[22:0] != 23'd0);
            inf1  <= sp_c && (in_f32[22:0] == 23'd0);
            norm1 <= !sp_c && (exp_f != 8'd0);
            man1  <= in_f32[22:0];
            k1    <= k_c;
        end
    end

    // S2: shift and round magnitude; a 64-bit window keeps lost high bits visible
    logic [63:0] m64, wide;
    logic [9:0]  neg_sh;
    logic [5:0]  rb_idx;
    logic        big, ovf_c;

    assign m64    = {40'd0, 1'b1, man1};
    assign neg_sh = -k1;
    assign rb_idx = {1'b0, neg_sh[4:0]} - 6'd1;

    always_comb begin
        wide = '0;
        big  = 1'b0;
        if (!k1[9]) begin
            if (k1 > 10'sd32) big = 1'b1;
            else              wide = m64 << k1[5:0];
        end else if (neg_sh < 10'd25) begin
            wide = (m64 >> neg_sh[4:0]) + {63'd0, m64[rb_idx]};
        end
    end

    assign ovf_c = big || (|wide[63:WL+1]);

    logic          v2, sign2, nan2, inf2, ovf2;
    logic [WL:0]   mag2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2 <= 1'b0;
        end else if (advance) begin
            v2    <= v1;
            sign2 <= sign1;
            nan2  <= nan1;
            inf2  <= inf1;
            ovf2  <= norm1 && ovf_c;
            mag2  <= norm1 ? wide[WL:0] : '0;
        end
    end

    // S3: apply sign and clip; -2^(WL-1) is representable so it is not a clip
    logic [WL:0]   neg_mag;
    logic [WL-1:0] val_c;
    logic          sat_c, nan_c;

    assign neg_mag = -mag2;

    always_comb begin
        val_c = '0;
        sat_c = 1'b0;
        nan_c = 1'b0;
        if (nan2) begin
            nan_c = 1'b1;
        end else if (inf2 || ovf2) begin
            sat_c = 1'b1;
            val_c = sign2 ? MINN : MAXP;
        end else if (sign2) begin
            if (mag2 > HALF) begin
                sat_c = 1'b1;
                val_c = MINN;
            end else begin
                val_c = neg_mag[WL-1:0];
            end
        end else if (mag2 > HALF_M1) begin
            sat_c = 1'b1;
            val_c = MAXP;
        end else begin
            val_c = mag2[WL-1:0];
        end
    end

    logic          v3, sat3, nan3;
    logic [WL-1:0] val3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v3 <= 1'b0;
        end else if (advance) begin
            v3   <= v2;
            val3 <= val_c;
            sat3 <= sat_c;
            nan3 <= nan_c;
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_val   <= '0;
            out_sat   <= 1'b0;
            out_nan   <= 1'b0;
        end else if (advance) begin
            out_valid <= v3;
            out_val   <= val3;
            out_sat   <= sat3;
            out_nan   <= nan3;
        end
    end

endmodule

// File: tb/tb_fp_f32_to_sfp.sv
// Bench for fp_f32_to_sfp: directed float words, a real-arithmetic reference
// model, literal expectations, stall, reset and latency checks.
module tb_fp_f32_to_sfp;

    localparam int IW = 4;
    localparam int QW = 12;
    localparam int WL = IW + QW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_f32 = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [WL-1:0] out_val;
    logic          out_sat;
    logic          out_nan;

    fp_f32_to_sfp #(.IW(IW), .QW(QW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_f32   (in_f32),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_val  (out_val),
        .out_sat  (out_sat),
        .out_nan  (out_nan)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   f;
        bit            lit;
        logic [WL-1:0] v;
        bit            s;
        bit            n;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: value = 1.man * 2^(exp-127), scaled by 2^QW in real arithmetic
    function automatic void model(input logic [31:0] f, output logic [WL-1:0] v,
                                  output bit s, output bit n);
        int     e;
        real    a;
        real    lim;
        longint m;
        longint half;
        v = '0; s = 0; n = 0;
        half = longint'(1) << (WL - 1);
        e = int'(f[30:23]);
        if (e == 255) begin
            if (f[22:0] != 0) n = 1;
            else begin
                s = 1;
                v = f[31] ? WL'(half) : WL'(half - 1);
            end
            return;
        end
        if (e == 0) return;
        a = 1.0 + real'(f[22:0]) / 8388608.0;
        e = e - 127 + QW;
        for (int i = 0; i < e; i++) a = a * 2.0;
        for (int i = 0; i < -e; i++) a = a * 0.5;
        lim = 1.0;
        for (int i = 0; i < WL; i++) lim = lim * 2.0;
        if (a >= lim) m = longint'(1) << WL;
        else m = longint'($rtoi(a + 0.5));
        if (!f[31]) begin
            if (m > half - 1) begin s = 1; v = WL'(half - 1); end
            else v = WL'(m);
        end else begin
            if (m > half) begin s = 1; v = WL'(half); end
            else v = WL'(-m);
        end
    endfunction

    // Compare process: every output transfer, plus hold-while-stalled
    logic [WL-1:0] pv;
    bit            ps, pn, was_stalled;
    exp_t          ce;
    logic [WL-1:0] mv;
    bit            ms, mn;

    always @(negedge clk) begin
        if (!rst_n) begin
            was_stalled = 0;
        end else begin
            if (was_stalled) begin
                chk("stall_valid_held", out_valid, 1);
                chk("stall_out_held", {out_val, out_sat, out_nan}, {pv, ps, pn});
            end
            chk("in_ready", in_ready, !out_valid || out_ready);
            if (out_valid)
                chk("flags_exclusive", out_sat & out_nan, 0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_output: got %h, expected none", out_val);
                end else begin
                    ce = q.pop_front();
                    model(ce.f, mv, ms, mn);
                    chk($sformatf("model_%h", ce.f), {out_val, out_sat, out_nan},
                        {mv, ms, mn});
                    if (ce.lit)
                        chk($sformatf("literal_%h", ce.f),
                            {out_val, out_sat, out_nan}, {ce.v, ce.s, ce.n});
                end
            end
            was_stalled = out_valid && !out_ready;
            pv = out_val; ps = out_sat; pn = out_nan;
        end
    end

    // Called just after a posedge; returns just after the accepting posedge
    task automatic send(input logic [31:0] f, input logic [WL-1:0] v,
                        input bit s, input bit n);
        exp_t e;
        int   g = 0;
        #1 in_valid = 1'b1;
        in_f32 = f;
        #1;
        while (!in_ready && g < 50) begin
            @(posedge clk);
            #2;
            g++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: in_ready got 0, expected 1");
        end
        @(posedge clk);
        e = '{f, 1'b1, v, s, n};
        q.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic latency(input string name);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 10);
        chk(name, n, 3);
    endtask

    localparam int NV = 22;
    logic [31:0]   tv_f [NV] = '{
        32'h3F800000, 32'hC0200000, 32'h00000000, 32'h80000000,
        32'h42C80000, 32'hC2C80000, 32'hC1000000, 32'h7F800000,
        32'hFF800000, 32'h39000000, 32'hB9000000, 32'h38800000,
        32'h00400000, 32'h7FC00000, 32'hFFFFFFFF, 32'h40FFFFFF,
        32'hC0FFFFFF, 32'h3F000000, 32'h39400000, 32'hB8C00000,
        32'h41000000, 32'h40FFFE00};
    logic [WL-1:0] tv_v [NV] = '{
        16'h1000, 16'hD800, 16'h0000, 16'h0000,
        16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF,
        16'h8000, 16'h0001, 16'hFFFF, 16'h0000,
        16'h0000, 16'h0000, 16'h0000, 16'h7FFF,
        16'h8000, 16'h0800, 16'h0001, 16'h0000,
        16'h7FFF, 16'h7FFF};
    bit tv_s [NV] = '{0,0,0,0, 1,1,0,1, 1,0,0,0, 0,0,0,1, 0,0,0,0, 1,0};
    bit tv_n [NV] = '{0,0,0,0, 0,0,0,0, 0,0,0,0, 0,1,1,0, 0,0,0,0, 0,0};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_word", {out_val, out_sat, out_nan}, 0);
        rst_n = 1'b1;
        @(posedge clk);

        send(32'h3F800000, 16'h1000, 0, 0);
        latency("latency_first");
        repeat (6) @(posedge clk);

        for (int i = 0; i < NV; i++)
            send(tv_f[i], tv_v[i], tv_s[i], tv_n[i]);
        repeat (8) @(posedge clk);

        fork
            begin
                send(32'h3F800000, 16'h1000, 0, 0);
                send(32'hC0200000, 16'hD800, 0, 0);
                send(32'h42C80000, 16'h7FFF, 1, 0);
                send(32'h7FC00000, 16'h0000, 0, 1);
                send(32'h39000000, 16'h0001, 0, 0);
                send(32'hC1000000, 16'h8000, 0, 0);
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        chk("backpressure_drained", q.size(), 0);

        send(32'h3F000000, 16'h0800, 0, 0);
        send(32'h40400000, 16'h3000, 0, 0);
        send(32'hBF800000, 16'hF000, 0, 0);
        rst_n = 1'b0;
        @(posedge clk);
        q.delete();
        #1;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_out_word", {out_val, out_sat, out_nan}, 0);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        send(32'h40A00000, 16'h5000, 0, 0);
        latency("latency_after_reset");
        repeat (6) @(posedge clk);

        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/fp_f32_to_sfp.md
Name: fp_f32_to_sfp

Overview:
Hardware float-to-fixed converter: takes IEEE-754 binary32 words and produces signed fixed-point (sfp) values with rounding and saturation. It is the synthesizable counterpart of the sim-only fixed-to-float view (fval) carried by the sfp signal. It sits at block boundaries where float-domain stimulus or coefficients enter the fixed-point datapath. It is a 3-stage pipeline with valid/ready handshakes on both sides.

Parameters:
IW, 4, integer bits of output, sign included; 1..31
QW, 12, fractional bits of output; 0..31; IW+QW <= 32
WL, IW+QW, localparam, output word length

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input word valid
in_ready  out  1  converter can accept input this cycle
in_f32  in  32  binary32 word {sign, exp[7:0], man[22:0]}
out_valid  out  1  output valid
out_ready  in  1  downstream accepts output
out_val  out  WL  signed fixed-point result, QW fractional bits (drives sfp.val)
out_sat  out  1  result clipped to range (or Inf input)
out_nan  out  1  input was NaN

Behaviour:
- Reset (rst_n low at clk edge): all stage valids = 0; out_valid = 0, out_val = 0, out_sat = 0, out_nan = 0. Reset mid-stream discards every in-flight word; no partial output.
- Pipeline: S1 unpack/classify, S2 shift+round magnitude, S3 negate+saturate, registered outputs. Global stall: advance = !out_valid | out_ready; in_ready = advance (combinational). Transfer on valid & ready, both sides.
- Latency: word accepted at edge N appears with out_valid at edge N+3 when out_ready stays 1. Throughput 1 word/cycle.
- Stall: while out_valid & !out_ready, out_val/out_sat/out_nan and all stage registers hold; no loss, no duplication, order preserved. Bubbles (invalid stages) do not block.
- Classification: exp=0 (zero/subnormal) -> 0, flags 0 (subnormals flushed). exp=255, man!=0 -> out_val 0, out_nan 1, out_sat 0. exp=255, man=0 -> +/-Inf -> saturate, out_sat 1.
- Normal: M = {1, man} (24 b). Shift k = exp - 150 + QW.
  - k >= 0: mag = M << k, computed wide enough (>= WL+1 bits, flag any shifted-out ones) to detect overflow.
  - k < 0: mag = M >> -k, round half away from zero on magnitude (add bit -k-1 before truncation). -k > 25 -> mag = 0.
- Saturation (S3), signed result r = sign ? -mag : mag: positive limit 2^(WL-1)-1, negative limit -2^(WL-1). mag = 2^(WL-1) with sign=1 is exact, out_sat 0. Any clip -> out_sat 1.
- Negative zero (-0.0) -> 0, flags 0. Rounding to zero of a nonzero input sets no flag.
- out_sat and out_nan are mutually exclusive; both qualified by out_valid.

Test Plan:
- IW=4,QW=12: in 0x3F800000 (1.0), out_ready=1 -> out_val 0x1000 exactly 3 cycles after accept; 0xC0200000 (-2.5) -> 0xD800; 0x00000000 and 0x80000000 -> 0x0000, flags 0.
- Saturation: 0x42C80000 (100.0) -> 0x7FFF sat=1; 0xC2C80000 -> 0x8000 sat=1; 0xC1000000 (-8.0) -> 0x8000 sat=0; 0x7F800000 (+Inf) -> 0x7FFF sat=1.
- Rounding: 0x39000000 (2^-13) -> 0x0001; 0xB9000000 -> 0xFFFF; 0x38800000 (2^-14) -> 0x0000; 0x00400000 (subnormal) -> 0x0000.
- NaN: 0x7FC00000 -> out_val 0x0000, nan=1, sat=0.
- Backpressure: 6 back-to-back words, out_ready low for cycles 2-6 -> in_ready low while stalled, outputs held stable, all 6 results emerge in order, none lost or duplicated.
- Reset mid-stream: 3 words in flight, rst_n low 1 cycle -> out_valid 0 next cycle, outputs 0, no stale words after release; next input converts with 3-cycle latency.
